ahb_slave_if: RTL

AHB-Lite slave front end that sits directly upstream of the APB controller FSM in the AHB-to-APB bridge.
- Pipelines the AHB address, control and write data into the two-deep staging registers the controller consumes.
- Generates the combinational `valid` qualifier and the one-hot peripheral select `tempselx`.
- Owns the AHB response path: HRDATA pass-through, HREADY merge and the two-cycle ERROR response for illegal transfers.

---
 rtl/bridge_pkg.sv | 33 +++
 rtl/ahb_slave_if.sv | 135 +++++++++++++
 2 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: AHB encodings, the error
// response state type and the default peripheral region map.
package bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [31:0] SLV0_BASE_DEFAULT   = 32'h8000_0000;
  localparam logic [31:0] SLV1_BASE_DEFAULT   = 32'h8400_0000;
  localparam logic [31:0] SLV2_BASE_DEFAULT   = 32'h8800_0000;
  localparam int unsigned REGION_BITS_DEFAULT = 26;

  typedef enum logic [1:0] {
    ERR_IDLE = 2'b00,
    ERR_1    = 2'b01,
    ERR_2    = 2'b10
  } errState_e;

  // True when addr falls inside the 2^bits-byte region starting at base.
  function automatic logic inRegion(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int unsigned bits);
    return (addr >> bits) == (base >> bits);
  endfunction

endpackage

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end of the AHB-to-APB bridge. Stages address and
// write data for the APB controller, decodes the peripheral select, and
// owns the AHB response path including the two-cycle ERROR response.
module ahb_slave_if
  import bridge_pkg::*;
#(
  parameter logic [31:0] SLV0_BASE   = SLV0_BASE_DEFAULT,
  parameter logic [31:0] SLV1_BASE   = SLV1_BASE_DEFAULT,
  parameter logic [31:0] SLV2_BASE   = SLV2_BASE_DEFAULT,
  parameter int unsigned REGION_BITS = REGION_BITS_DEFAULT
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic        hwrite,
  input  logic        hreadyin,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic [31:0] prdata,
  input  logic        apb_hreadyout,
  output logic        valid,
  output logic [31:0] haddr1,
  output logic [31:0] haddr2,
  output logic [31:0] hwdata1,
  output logic [31:0] hwdata2,
  output logic        hwritereg,
  output logic [2:0]  tempselx,
  output logic [31:0] hrdata,
  output logic [1:0]  hresp,
  output logic        hready_o
);

  logic [31:0] haddr1_q;
  logic [31:0] haddr2_q;
  logic [31:0] hwdata1_q;
  logic [31:0] hwdata2_q;
  logic        hwrite_q;

  errState_e   errState_q;
  logic [1:0]  hresp_q;
  logic        errStall_q;

  logic        active;
  logic        legal;
  logic        illegalSample;

  // Region decode and transfer qualification, all on the live address phase.
  always_comb begin
    tempselx = 3'b000;
    if (inRegion(haddr, SLV0_BASE, REGION_BITS)) begin
      tempselx = 3'b001;
    end else if (inRegion(haddr, SLV1_BASE, REGION_BITS)) begin
      tempselx = 3'b010;
    end else if (inRegion(haddr, SLV2_BASE, REGION_BITS)) begin
      tempselx = 3'b100;
    end
    active        = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    legal         = (tempselx != 3'b000) && (hsize == HSIZE_WORD) &&
                    (haddr[1:0] == 2'b00);
    valid         = hresetn && hreadyin && active && legal;
    illegalSample = hreadyin && active && !legal;
  end

  // Two-deep address/data staging; everything holds while the bus stalls.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr1_q  <= 32'h0;
      haddr2_q  <= 32'h0;
      hwdata1_q <= 32'h0;
      hwdata2_q <= 32'h0;
      hwrite_q  <= 1'b0;
    end else if (hreadyin) begin
      haddr1_q  <= haddr;
      haddr2_q  <= haddr1_q;
      hwdata1_q <= hwdata;
      hwdata2_q <= hwdata1_q;
      hwrite_q  <= hwrite;
    end
  end

  // Error response FSM: stall one cycle with ERROR, then complete with ERROR.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      errState_q <= ERR_IDLE;
      hresp_q    <= HRESP_OKAY;
      errStall_q <= 1'b0;
    end else begin
      case (errState_q)
        ERR_IDLE: begin
          if (illegalSample) begin
            errState_q <= ERR_1;
            hresp_q    <= HRESP_ERROR;
            errStall_q <= 1'b1;
          end
        end
        ERR_1: begin
          errState_q <= ERR_2;
          hresp_q    <= HRESP_ERROR;
          errStall_q <= 1'b0;
        end
        ERR_2: begin
          if (illegalSample) begin
            errState_q <= ERR_1;
            hresp_q    <= HRESP_ERROR;
            errStall_q <= 1'b1;
          end else begin
            errState_q <= ERR_IDLE;
            hresp_q    <= HRESP_OKAY;
            errStall_q <= 1'b0;
          end
        end
        default: begin
          errState_q <= ERR_IDLE;
          hresp_q    <= HRESP_OKAY;
          errStall_q <= 1'b0;
        end
      endcase
    end
  end

  // Outside an error sequence the controller's ready drives the bus.
  always_comb begin
    hready_o = (errState_q == ERR_IDLE) ? apb_hreadyout : !errStall_q;
  end

  assign haddr1    = haddr1_q;
  assign haddr2    = haddr2_q;
  assign hwdata1   = hwdata1_q;
  assign hwdata2   = hwdata2_q;
  assign hwritereg = hwrite_q;
  assign hresp     = hresp_q;
  assign hrdata    = prdata;

endmodule
